// File: rtl/glay_cu_cache_req_arbiter.sv
// rtl/glay_cu_cache_req_arbiter.sv - round-robin N-channel request queue front end for the CU cache port
module glay_cu_cache_req_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 512,
    parameter int FIFO_DEPTH   = 16,
    localparam int CH_W        = $clog2(NUM_CHANNELS),
    localparam int STRB_W      = DATA_W / 8
) (
    input  logic                           ap_clk,
    input  logic                           areset,
    input  logic [NUM_CHANNELS-1:0]        req_valid,
    output logic [NUM_CHANNELS-1:0]        req_ready,
    input  logic [NUM_CHANNELS*ADDR_W-1:0] req_addr,
    input  logic [NUM_CHANNELS*DATA_W-1:0] req_wdata,
    input  logic [NUM_CHANNELS*STRB_W-1:0] req_wstrb,
    output logic                           cache_valid,
    output logic [ADDR_W-1:0]              cache_addr,
    output logic [DATA_W-1:0]              cache_wdata,
    output logic [STRB_W-1:0]              cache_wstrb,
    input  logic                           cache_ready,
    input  logic [DATA_W-1:0]              cache_rdata,
    output logic [NUM_CHANNELS-1:0]        rsp_valid,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic [CH_W-1:0]                grant_ch,
    output logic                           idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CHANNELS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Per-channel queue bookkeeping
    logic [PTR_W:0]   count_q  [NUM_CHANNELS];
    logic [PTR_W:0]   count_d  [NUM_CHANNELS];
    logic [PTR_W-1:0] wr_ptr_q [NUM_CHANNELS];
    logic [PTR_W-1:0] wr_ptr_d [NUM_CHANNELS];
    logic [PTR_W-1:0] rd_ptr_q [NUM_CHANNELS];
    logic [PTR_W-1:0] rd_ptr_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] req_ready_q, req_ready_d;
    logic [NUM_CHANNELS-1:0] push, pop;

    // Queue storage
    logic [ADDR_W-1:0] mem_addr  [NUM_CHANNELS][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_wdata [NUM_CHANNELS][FIFO_DEPTH];
    logic [STRB_W-1:0] mem_wstrb [NUM_CHANNELS][FIFO_DEPTH];

    // Arbitration and cache-side registers
    logic [CH_W-1:0]         last_grant_q, last_grant_d;
    logic [CH_W-1:0]         grant_ch_q, grant_ch_d;
    logic [CH_W-1:0]         winner;
    logic                    found;
    logic                    cache_valid_q, cache_valid_d;
    logic [ADDR_W-1:0]       cache_addr_q, cache_addr_d;
    logic [DATA_W-1:0]       cache_wdata_q, cache_wdata_d;
    logic [STRB_W-1:0]       cache_wstrb_q, cache_wstrb_d;
    logic [NUM_CHANNELS-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;

    // A push only happens against the registered ready, so a full queue never overflows.
    always_comb begin
        push = req_valid & req_ready_q;
    end

    // Round-robin scan starting one past the last winner; found doubles as "some queue is non-empty".
    always_comb begin
        logic [CH_W-1:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            idx = CH_W'((int'(last_grant_q) + i) % NUM_CHANNELS);
            if (!found && (count_q[idx] != '0)) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Issue FSM: pop the winner into the cache registers, hold until completion, then pulse the response.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_ch_d    = grant_ch_q;
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        cache_wdata_d = cache_wdata_q;
        cache_wstrb_d = cache_wstrb_q;
        rsp_valid_d   = '0;
        rsp_rdata_d   = rsp_rdata_q;
        pop           = '0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    pop[winner]   = 1'b1;
                    cache_valid_d = 1'b1;
                    cache_addr_d  = mem_addr[winner][rd_ptr_q[winner]];
                    cache_wdata_d = mem_wdata[winner][rd_ptr_q[winner]];
                    cache_wstrb_d = mem_wstrb[winner][rd_ptr_q[winner]];
                    grant_ch_d    = winner;
                    last_grant_d  = winner;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cache_ready) begin
                    cache_valid_d          = 1'b0;
                    rsp_valid_d[grant_ch_q] = 1'b1;
                    rsp_rdata_d            = cache_rdata;
                    state_d                = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Queue pointer/count update; ready is registered from the post-update count.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            wr_ptr_d[c]    = wr_ptr_q[c] + PTR_W'(push[c]);
            rd_ptr_d[c]    = rd_ptr_q[c] + PTR_W'(pop[c]);
            count_d[c]     = count_q[c] + (PTR_W + 1)'(push[c]) - (PTR_W + 1)'(pop[c]);
            req_ready_d[c] = (count_d[c] != FULL_CNT);
        end
    end

    // Control state with asynchronous reset; reset drops any in-flight transaction and queued entries.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= LAST_CH;
            grant_ch_q    <= '0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_wdata_q <= '0;
            cache_wstrb_q <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            req_ready_q   <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                count_q[c]  <= '0;
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_ch_q    <= grant_ch_d;
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
            cache_wdata_q <= cache_wdata_d;
            cache_wstrb_q <= cache_wstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            req_ready_q   <= req_ready_d;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                count_q[c]  <= count_d[c];
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
            end
        end
    end

    // Queue storage write; contents need no reset because count gates every read.
    always_ff @(posedge ap_clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (push[c]) begin
                mem_addr[c][wr_ptr_q[c]]  <= req_addr[c*ADDR_W +: ADDR_W];
                mem_wdata[c][wr_ptr_q[c]] <= req_wdata[c*DATA_W +: DATA_W];
                mem_wstrb[c][wr_ptr_q[c]] <= req_wstrb[c*STRB_W +: STRB_W];
            end
        end
    end

    assign req_ready   = req_ready_q;
    assign cache_valid = cache_valid_q;
    assign cache_addr  = cache_addr_q;
    assign cache_wdata = cache_wdata_q;
    assign cache_wstrb = cache_wstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign grant_ch    = grant_ch_q;
    assign idle        = (state_q == ST_IDLE) && !found;

endmodule
